// File: rtl/core_bus_arbiter.sv
// Two-master, one-slave arbiter for the cyc/stb/we/ack core bus.
// Grants are held for a whole cyc tenure; ties go round-robin; a watchdog errors stalled slaves.
module core_bus_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [BUS_WIDTH-1:0] m0_addr_i,
  input  logic [BUS_WIDTH-1:0] m0_data_i,
  output logic [BUS_WIDTH-1:0] m0_data_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [BUS_WIDTH-1:0] m1_addr_i,
  input  logic [BUS_WIDTH-1:0] m1_data_i,
  output logic [BUS_WIDTH-1:0] m1_data_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [BUS_WIDTH-1:0] s_addr_o,
  output logic [BUS_WIDTH-1:0] s_data_o,
  input  logic [BUS_WIDTH-1:0] s_data_i,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt_o
);

  // Owner is kept one-hot so it doubles as the registered gnt_o.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  localparam int WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  logic [1:0]           owner_reg, owner_next;
  logic                 last_reg, last_next;
  logic [WD_W-1:0]      wd_reg, wd_next;
  logic                 own_cyc, own_stb, own_we;
  logic [BUS_WIDTH-1:0] own_addr, own_data;
  logic                 timeout;
  logic                 ack_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= OWN_NONE;
      last_reg  <= 1'b1;
      wd_reg    <= '0;
    end else begin
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wd_reg    <= wd_next;
    end
  end

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    case (owner_reg)
      OWN_M0: begin
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_addr = m0_addr_i;
        own_data = m0_data_i;
      end
      OWN_M1: begin
        own_cyc  = m1_cyc_i;
        own_stb  = m1_stb_i;
        own_we   = m1_we_i;
        own_addr = m1_addr_i;
        own_data = m1_data_i;
      end
      default: ;
    endcase
  end

  // An ack in the same cycle always beats the watchdog.
  assign timeout = (TIMEOUT_CYCLES > 0) && own_cyc && own_stb && !s_ack_i && (wd_reg == WD_LAST);

  always_comb begin
    owner_next = owner_reg;
    last_next  = last_reg;
    if (owner_reg == OWN_NONE || !own_cyc) begin
      if (m0_cyc_i && m1_cyc_i) begin
        owner_next = last_reg ? OWN_M0 : OWN_M1;
        last_next  = ~last_reg;
      end else if (m0_cyc_i) begin
        owner_next = OWN_M0;
        last_next  = 1'b0;
      end else if (m1_cyc_i) begin
        owner_next = OWN_M1;
        last_next  = 1'b1;
      end else begin
        owner_next = OWN_NONE;
      end
    end

    if (owner_next != owner_reg || !(own_cyc && own_stb) || s_ack_i || timeout)
      wd_next = '0;
    else
      wd_next = wd_reg + 1'b1;
  end

  assign ack_hit = s_ack_i && own_cyc && own_stb;

  always_comb begin
    gnt_o     = owner_reg;
    s_cyc_o   = own_cyc;
    s_stb_o   = own_stb && !timeout;
    s_we_o    = own_we;
    s_addr_o  = own_addr;
    s_data_o  = own_data;
    m0_ack_o  = (owner_reg == OWN_M0) && ack_hit;
    m1_ack_o  = (owner_reg == OWN_M1) && ack_hit;
    m0_err_o  = (owner_reg == OWN_M0) && timeout;
    m1_err_o  = (owner_reg == OWN_M1) && timeout;
    // Read data is shared; held at zero while reset is asserted.
    m0_data_o = rst_n ? s_data_i : '0;
    m1_data_o = rst_n ? s_data_i : '0;
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: watchdog at 4 cycles, plus a disabled-watchdog copy.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] s_rdata = 0;
  logic        s_ack = 0;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [1:0]  gnt;

  logic [31:0] z_m0_rdata, z_m1_rdata, z_s_addr, z_s_wdata;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
  logic [1:0]  z_gnt;

  int n_total = 0;
  int n_pass  = 0;
  int err4_cnt, err0_cnt;

  always #5 clk = ~clk;

  core_bus_arbiter #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_data_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_data_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wdata),
    .s_data_i(s_rdata), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  core_bus_arbiter #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nowd (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_data_o(z_m0_rdata), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_data_o(z_m1_rdata), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_addr_o(z_s_addr), .s_data_o(z_s_wdata),
    .s_data_i(s_rdata), .s_ack_i(s_ack), .gnt_o(z_gnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle of master/slave handshakes at the falling edge, then settle.
  task automatic step(input logic c0, input logic s0, input logic c1, input logic s1, input logic ack);
    @(negedge clk);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
    #1;
  endtask

  initial begin
    // Reset held with both masters requesting
    step(1, 1, 1, 1, 1);
    s_rdata = 32'h5555_5555; #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_scyc", s_cyc, 0);
    check("rst_m0ack", m0_ack, 0);
    check("rst_m0data", m0_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1; s_ack = 1'b0; #1;
    check("rel_gnt", gnt, 2'b00);
    check("rel_scyc", s_cyc, 0);

    // First tie after reset goes to M0; M0 does three acked reads
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 1);
      s_rdata = 32'h100 + i; #1;
      check($sformatf("rd%0d_gnt", i), gnt, 2'b01);
      check($sformatf("rd%0d_m0ack", i), m0_ack, 1);
      check($sformatf("rd%0d_m1ack", i), m1_ack, 0);
      check($sformatf("rd%0d_m0data", i), m0_rdata, 32'h100 + i);
    end

    // Alternating tenures with no idle cycle between them
    step(0, 0, 1, 1, 0);
    check("ho1_gnt", gnt, 2'b01);
    check("ho1_scyc", s_cyc, 0);
    step(1, 1, 1, 1, 1);
    check("rr1_gnt", gnt, 2'b10);
    check("rr1_m1ack", m1_ack, 1);
    check("rr1_m0ack", m0_ack, 0);
    step(1, 1, 0, 0, 0);
    check("ho2_scyc", s_cyc, 0);
    step(1, 1, 1, 1, 1);
    check("rr2_gnt", gnt, 2'b01);
    check("rr2_m0ack", m0_ack, 1);
    step(0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    check("rr3_gnt", gnt, 2'b10);
    check("rr3_m1ack", m1_ack, 1);

    // M0 takes a solo tenure, bus idles, then a tie must go to M1
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("solo_gnt", gnt, 2'b01);
    step(1, 1, 1, 1, 0);
    check("idle_gnt", gnt, 2'b00);
    check("idle_scyc", s_cyc, 0);
    check("idle_sstb", s_stb, 0);

    // Routing: M1 write then read
    m1_we = 1; m1_addr = 32'h0000_0100; m1_wdata = 32'hDEAD_BEEF;
    m0_addr = 32'h0000_AAAA; m0_wdata = 32'h1111_1111;
    step(1, 1, 1, 1, 1);
    check("tie_gnt", gnt, 2'b10);
    check("wr_saddr", s_addr, 32'h0000_0100);
    check("wr_sdata", s_wdata, 32'hDEAD_BEEF);
    check("wr_swe", s_we, 1);
    check("wr_m1ack", m1_ack, 1);
    m1_we = 0; s_rdata = 32'h1234_5678;
    step(1, 1, 1, 1, 1);
    check("rd_m1data", m1_rdata, 32'h1234_5678);
    check("rd_m1ack", m1_ack, 1);
    check("rd_m0ack", m0_ack, 0);
    check("rd_swe", s_we, 0);

    // Watchdog: M0 stalls; err on every 4th stall cycle with stb forced low
    step(1, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 0, 0);
      check($sformatf("st%0d_gnt", i), gnt, 2'b01);
      check($sformatf("st%0d_err", i), m0_err, (i % 4 == 0));
      check($sformatf("st%0d_sstb", i), s_stb, (i % 4 != 0));
      check($sformatf("st%0d_ack", i), m0_ack, 0);
    end
    for (int i = 9; i <= 11; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    check("acktmo_ack", m0_ack, 1);
    check("acktmo_err", m0_err, 0);
    check("acktmo_sstb", s_stb, 1);

    // 1000 stalled cycles: watchdog copy errs 250 times, disabled copy never
    err4_cnt = 0; err0_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 1, 0, 0, 0);
      if (m0_err) err4_cnt++;
      if (z_m0_err) err0_cnt++;
    end
    check("wd4_errs", err4_cnt, 250);
    check("wd0_errs", err0_cnt, 0);
    check("wd0_gnt", z_gnt, 2'b01);

    // Asynchronous reset in the middle of an M1 tenure
    m1_we = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'hCAFE_F00D;
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    check("mr_gnt", gnt, 2'b10);
    check("mr_scyc", s_cyc, 1);
    #2; rst_n = 1'b0; s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
    #1;
    check("ar_gnt", gnt, 2'b00);
    check("ar_scyc", s_cyc, 0);
    check("ar_sstb", s_stb, 0);
    check("ar_swe", s_we, 0);
    check("ar_saddr", s_addr, 32'h0);
    check("ar_sdata", s_wdata, 32'h0);
    check("ar_m1ack", m1_ack, 0);
    check("ar_m1err", m1_err, 0);
    check("ar_m1data", m1_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1; s_ack = 1'b0; #1;
    check("arrel_gnt", gnt, 2'b00);
    @(negedge clk); #1;
    check("arg_gnt", gnt, 2'b10);
    check("arg_scyc", s_cyc, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
